// File: rtl/lea128_key_sched_ctrl.sv
// Iterative LEA-128 key schedule: loads a 128-bit master key and streams
// 24 round keys of 192 bits over a valid/ready port, one round per cycle.
`timescale 1ns/1ps
module lea128_key_sched_ctrl #(
  parameter int unsigned ROUNDS = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [191:0] rk,
  output logic [4:0]   rk_idx,
  output logic         done,
  output logic [1:0]   dbg_state
);

  // Handshake: a key moves on any cycle with rk_valid && rk_ready. While
  // rk_valid && !rk_ready, rk/rk_idx/T-words hold and rk_valid stays high.
  // rk_valid, rk and rk_idx come straight from flops, so rk_ready has no
  // combinational path to them.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [4:0] LAST = 5'(ROUNDS - 1);

  state_t         state_q, state_d;
  logic [31:0]    t0_q, t1_q, t2_q, t3_q;
  logic [31:0]    t0_d, t1_d, t2_d, t3_d;
  logic [4:0]     round_q, round_d;
  logic           busy_q, busy_d;
  logic           rk_valid_q, rk_valid_d;
  logic [191:0]   rk_q, rk_d;
  logic [4:0]     rk_idx_q, rk_idx_d;
  logic           done_q, done_d;

  logic [31:0]    d;
  logic [31:0]    n0, n1, n2, n3;
  logic           load;
  logic           xfer;

  function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] dbl;
    dbl = {x, x} << n;
    return dbl[63:32];
  endfunction

  function automatic logic [31:0] delta_sel(input logic [1:0] sel);
    logic [31:0] v;
    case (sel)
      2'd0:    v = 32'hc3efe9db;
      2'd1:    v = 32'h44626b02;
      2'd2:    v = 32'h79e27c8a;
      default: v = 32'h78df30ec;
    endcase
    return v;
  endfunction

  // Single shared round datapath; round_q + 3 peaks at 26, so no wrap.
  always_comb begin
    d  = delta_sel(round_q[1:0]);
    n0 = rol32(t0_q + rol32(d, round_q),         5'd1);
    n1 = rol32(t1_q + rol32(d, round_q + 5'd1),  5'd3);
    n2 = rol32(t2_q + rol32(d, round_q + 5'd2),  5'd6);
    n3 = rol32(t3_q + rol32(d, round_q + 5'd3),  5'd11);
  end

  assign load = !rk_valid_q || rk_ready;
  assign xfer = rk_valid_q && rk_ready;

  always_comb begin
    state_d    = state_q;
    t0_d       = t0_q;
    t1_d       = t1_q;
    t2_d       = t2_q;
    t3_d       = t3_q;
    round_d    = round_q;
    busy_d     = busy_q;
    rk_valid_d = rk_valid_q;
    rk_d       = rk_q;
    rk_idx_d   = rk_idx_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          t0_d    = key[31:0];
          t1_d    = key[63:32];
          t2_d    = key[95:64];
          t3_d    = key[127:96];
          round_d = '0;
          busy_d  = 1'b1;
          state_d = GEN;
        end
      end
      GEN: begin
        // Load the next round whenever the output register frees up,
        // including the cycle it is being drained (zero-bubble streaming).
        if (load) begin
          rk_d       = {n1, n3, n1, n2, n1, n0};
          rk_idx_d   = round_q;
          rk_valid_d = 1'b1;
          t0_d       = n0;
          t1_d       = n1;
          t2_d       = n2;
          t3_d       = n3;
          round_d    = round_q + 5'd1;
          if (round_q == LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer) begin
          rk_valid_d = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      t0_q       <= '0;
      t1_q       <= '0;
      t2_q       <= '0;
      t3_q       <= '0;
      round_q    <= '0;
      busy_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_q       <= '0;
      rk_idx_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      t0_q       <= t0_d;
      t1_q       <= t1_d;
      t2_q       <= t2_d;
      t3_q       <= t3_d;
      round_q    <= round_d;
      busy_q     <= busy_d;
      rk_valid_q <= rk_valid_d;
      rk_q       <= rk_d;
      rk_idx_q   <= rk_idx_d;
      done_q     <= done_d;
    end
  end

  assign busy      = busy_q;
  assign rk_valid  = rk_valid_q;
  assign rk        = rk_q;
  assign rk_idx    = rk_idx_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
